// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter sharing one slave bus between the instruction
// fetch and data ports, one transaction in flight, with a per-transaction ack timeout.
module bus_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_access,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic        d_access,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic        m_access,
  output logic [31:0] m_addr,
  output logic [3:0]  m_bytesel,
  output logic        m_wr_en,
  output logic [31:0] m_wr_val,
  input  logic [31:0] m_data,
  input  logic        m_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        grant, grant_nx;            // 0 = instruction port, 1 = data port
  logic        last_grant, last_grant_nx;
  logic [7:0]  tcount, tcount_nx;
  logic        m_access_nx;
  logic [31:0] m_addr_nx;
  logic [3:0]  m_bytesel_nx;
  logic        m_wr_en_nx;
  logic [31:0] m_wr_val_nx;
  logic [31:0] i_data_nx, d_data_nx;
  logic        i_ack_nx, i_error_nx, d_ack_nx, d_error_nx;
  logic [31:0] rsp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b0;
      tcount     <= 8'd0;
      m_access   <= 1'b0;
      m_addr     <= 32'd0;
      m_bytesel  <= 4'd0;
      m_wr_en    <= 1'b0;
      m_wr_val   <= 32'd0;
      i_data     <= 32'd0;
      i_ack      <= 1'b0;
      i_error    <= 1'b0;
      d_data     <= 32'd0;
      d_ack      <= 1'b0;
      d_error    <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      tcount     <= tcount_nx;
      m_access   <= m_access_nx;
      m_addr     <= m_addr_nx;
      m_bytesel  <= m_bytesel_nx;
      m_wr_en    <= m_wr_en_nx;
      m_wr_val   <= m_wr_val_nx;
      i_data     <= i_data_nx;
      i_ack      <= i_ack_nx;
      i_error    <= i_error_nx;
      d_data     <= d_data_nx;
      d_ack      <= d_ack_nx;
      d_error    <= d_error_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    tcount_nx     = tcount;
    m_access_nx   = m_access;
    m_addr_nx     = m_addr;
    m_bytesel_nx  = m_bytesel;
    m_wr_en_nx    = m_wr_en;
    m_wr_val_nx   = m_wr_val;
    i_data_nx     = 32'd0;
    i_ack_nx      = 1'b0;
    i_error_nx    = 1'b0;
    d_data_nx     = 32'd0;
    d_ack_nx      = 1'b0;
    d_error_nx    = 1'b0;
    rsp_data      = 32'd0;

    case (state)
      IDLE: begin
        if (i_access || d_access) begin
          // On contention the port that was not served last wins.
          grant_nx    = d_access && (!i_access || !last_grant);
          state_nx    = BUSY;
          m_access_nx = 1'b1;
          tcount_nx   = 8'd0;
          if (grant_nx) begin
            m_addr_nx    = d_addr;
            m_bytesel_nx = d_bytesel;
            m_wr_en_nx   = d_wr_en;
            m_wr_val_nx  = d_wr_val;
          end else begin
            m_addr_nx    = i_addr;
            m_bytesel_nx = 4'hF;
            m_wr_en_nx   = 1'b0;
            m_wr_val_nx  = 32'd0;
          end
        end
      end

      BUSY: begin
        // A real ack on the last allowed cycle beats the timeout.
        if (m_ack || tcount == TC_LAST) begin
          rsp_data = (m_ack && !m_wr_en) ? m_data : 32'd0;
          if (grant) begin
            d_ack_nx   = 1'b1;
            d_error_nx = !m_ack;
            d_data_nx  = rsp_data;
          end else begin
            i_ack_nx   = 1'b1;
            i_error_nx = !m_ack;
            i_data_nx  = rsp_data;
          end
          last_grant_nx = grant;
          state_nx      = DONE;
          m_access_nx   = 1'b0;
          m_addr_nx     = 32'd0;
          m_bytesel_nx  = 4'd0;
          m_wr_en_nx    = 1'b0;
          m_wr_val_nx   = 32'd0;
        end else begin
          tcount_nx = tcount + 8'd1;
        end
      end

      DONE: state_nx = IDLE;

      default: state_nx = IDLE;
    endcase
  end

endmodule
